// File: rtl/cpu_pkg.sv
// Shared types for the CPU output-port slice.
// Holds the transmitter state encoding and the idle level of the serial line.
package cpu_pkg;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    localparam logic TX_LINE_IDLE = 1'b1;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a combinational head read.
// A pop on an empty FIFO with a simultaneous push passes wdata straight through.
module sync_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          push,
    input  logic                          pop,
    input  logic [DATA_W-1:0]             wdata,
    output logic [DATA_W-1:0]             rdata,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          full,
    output logic                          empty
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;
    logic              w_wr;
    logic              w_rd;

    assign full  = (r_count == CW'(FIFO_DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;
    assign rdata = empty ? wdata : r_mem[r_rptr];

    // A pop frees a slot in the same cycle, so a full FIFO still accepts.
    assign w_wr = push && (!full || pop);
    assign w_rd = pop && (!empty || push);

    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr)
                r_wptr <= r_wptr + 1'b1;
            if (w_rd)
                r_rptr <= r_rptr + 1'b1;
            if (w_wr && !w_rd)
                r_count <= r_count + 1'b1;
            else if (w_rd && !w_wr)
                r_count <= r_count - 1'b1;
        end
    end

endmodule

// File: rtl/out_port_tx.sv
// 8N1 serial transmitter fed by CPU OUT-register writes.
// Writes are buffered in a FIFO; overflow is sticky and never stalls the CPU.
module out_port_tx
    import cpu_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          write_o,
    input  logic [DATA_W-1:0]             C_in,
    input  logic                          ovf_clr,
    output logic                          tx_serial,
    output logic                          tx_busy,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    tx_state_t         r_state;
    logic [BW-1:0]     r_bcnt;
    logic [IW-1:0]     r_bidx;
    logic [DATA_W-1:0] r_shreg;
    logic              r_tx;
    logic              r_busy;
    logic              r_ovf;

    logic [DATA_W-1:0] w_rdata;
    logic              w_empty;
    logic              w_bit_end;
    logic              w_pop;

    assign w_bit_end = (r_bcnt == BW'(CLKS_PER_BIT - 1));

    // At the end of STOP a same-cycle write is taken through the FIFO bypass.
    assign w_pop = ((r_state == TX_IDLE) && !w_empty) ||
                   ((r_state == TX_STOP) && w_bit_end && (!w_empty || write_o));

    sync_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (write_o),
        .pop   (w_pop),
        .wdata (C_in),
        .rdata (w_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (w_empty)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= TX_IDLE;
            r_bcnt  <= '0;
            r_bidx  <= '0;
            r_shreg <= '0;
            r_tx    <= TX_LINE_IDLE;
            r_busy  <= 1'b0;
        end else begin
            unique case (r_state)
                TX_IDLE: begin
                    if (w_pop) begin
                        r_shreg <= w_rdata;
                        r_bcnt  <= '0;
                        r_tx    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (w_bit_end) begin
                        r_bcnt  <= '0;
                        r_bidx  <= '0;
                        r_tx    <= r_shreg[0];
                        r_state <= TX_DATA;
                    end else begin
                        r_bcnt <= r_bcnt + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (w_bit_end) begin
                        r_bcnt <= '0;
                        if (r_bidx == IW'(DATA_W - 1)) begin
                            r_tx    <= TX_LINE_IDLE;
                            r_state <= TX_STOP;
                        end else begin
                            r_shreg <= r_shreg >> 1;
                            r_tx    <= r_shreg[1];
                            r_bidx  <= r_bidx + 1'b1;
                        end
                    end else begin
                        r_bcnt <= r_bcnt + 1'b1;
                    end
                end
                TX_STOP: begin
                    if (w_bit_end) begin
                        r_bcnt <= '0;
                        if (w_pop) begin
                            r_shreg <= w_rdata;
                            r_tx    <= 1'b0;
                            r_state <= TX_START;
                        end else begin
                            r_tx    <= TX_LINE_IDLE;
                            r_busy  <= 1'b0;
                            r_state <= TX_IDLE;
                        end
                    end else begin
                        r_bcnt <= r_bcnt + 1'b1;
                    end
                end
                default: r_state <= TX_IDLE;
            endcase
        end
    end

    // Set wins over clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            r_ovf <= 1'b0;
        else if (write_o && fifo_full && !w_pop)
            r_ovf <= 1'b1;
        else if (ovf_clr)
            r_ovf <= 1'b0;
    end

    assign tx_serial = r_tx;
    assign tx_busy   = r_busy;
    assign overflow  = r_ovf;

endmodule

// File: tb/tb_out_port_tx.sv
// Scoreboard bench for out_port_tx: a serial-line monitor decodes frames
// and compares them against bytes queued by the directed stimulus.
module tb_out_port_tx;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       write_o = 1'b0;
    logic [7:0] C_in = 8'h00;
    logic       ovf_clr = 1'b0;
    logic       tx_serial;
    logic       tx_busy;
    logic       fifo_full;
    logic [2:0] fifo_count;
    logic       overflow;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] sb[$];
    bit mon_abort = 1'b0;

    out_port_tx #(
        .DATA_W       (8),
        .CLKS_PER_BIT (4),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .write_o    (write_o),
        .C_in       (C_in),
        .ovf_clr    (ovf_clr),
        .tx_serial  (tx_serial),
        .tx_busy    (tx_busy),
        .fifo_full  (fifo_full),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge rstn) mon_abort = 1'b1;

    // Line monitor: start bit at n=0, sample bit centres every 4 negedges.
    initial begin : monitor
        logic [7:0] d;
        logic [7:0] e;
        logic       st;
        logic       sp;
        forever begin
            @(negedge clk);
            if (rstn === 1'b1 && tx_serial === 1'b0) begin
                mon_abort = 1'b0;
                repeat (2) @(negedge clk);
                st = tx_serial;
                for (int i = 0; i < 8; i++) begin
                    repeat (4) @(negedge clk);
                    d[i] = tx_serial;
                end
                repeat (4) @(negedge clk);
                sp = tx_serial;
                if (!mon_abort) begin
                    check("start_bit", {31'd0, st}, 32'd0);
                    check("stop_bit", {31'd0, sp}, 32'd1);
                    if (sb.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_frame: got %0h expected none", d);
                    end else begin
                        e = sb.pop_front();
                        check("frame_data", {24'd0, d}, {24'd0, e});
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic write_seq(input logic [7:0] first, input int n,
                             input int n_keep);
        for (int i = 0; i < n; i++) begin
            write_o = 1'b1;
            C_in    = first + 8'(i);
            if (i < n_keep)
                sb.push_back(C_in);
            @(negedge clk);
        end
        write_o = 1'b0;
    endtask

    task automatic measure_busy(output int len, output int peak,
                                output bit full_seen);
        int w;
        len = 0;
        peak = 0;
        full_seen = 1'b0;
        w = 0;
        do begin
            @(negedge clk);
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
            if (fifo_full) full_seen = 1'b1;
            w++;
        end while (!tx_busy && w < 10);
        while (tx_busy && len < 2000) begin
            len++;
            @(negedge clk);
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
            if (fifo_full) full_seen = 1'b1;
        end
    endtask

    initial begin : main
        int len;
        int peak;
        bit fs;
        bit seen;

        repeat (3) @(negedge clk);
        rstn = 1'b1;

        // 1: idle after reset
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_tx", {31'd0, tx_serial}, 32'd1);
            check("idle_busy", {31'd0, tx_busy}, 32'd0);
            check("idle_count", {29'd0, fifo_count}, 32'd0);
            check("idle_ovf", {31'd0, overflow}, 32'd0);
        end

        // 2: single 0xA5
        write_o = 1'b1;
        C_in = 8'hA5;
        sb.push_back(8'hA5);
        @(negedge clk);
        write_o = 1'b0;
        check("lat_pre_tx", {31'd0, tx_serial}, 32'd1);
        check("lat_pre_count", {29'd0, fifo_count}, 32'd1);
        @(negedge clk);
        check("lat_start_tx", {31'd0, tx_serial}, 32'd0);
        check("lat_start_busy", {31'd0, tx_busy}, 32'd1);
        check("lat_start_count", {29'd0, fifo_count}, 32'd0);
        len = 0;
        while (tx_busy && len < 200) begin
            len++;
            @(negedge clk);
        end
        check("a5_busy_len", len, 32'd40);
        repeat (5) @(negedge clk);

        // 3: three back-to-back
        fork
            write_seq(8'h01, 3, 3);
            measure_busy(len, peak, fs);
        join
        check("b2b_busy_len", len, 32'd120);
        check("b2b_peak", peak, 32'd2);
        repeat (5) @(negedge clk);

        // 4: overflow
        fork
            begin
                write_seq(8'h10, 6, 5);
                check("ovf_full", {31'd0, fifo_full}, 32'd1);
                check("ovf_set", {31'd0, overflow}, 32'd1);
                write_o = 1'b1;
                C_in = 8'h99;
                ovf_clr = 1'b1;
                @(negedge clk);
                write_o = 1'b0;
                ovf_clr = 1'b0;
                check("ovf_set_wins", {31'd0, overflow}, 32'd1);
                check("ovf_count_kept", {29'd0, fifo_count}, 32'd4);
                @(negedge clk);
                ovf_clr = 1'b1;
                @(negedge clk);
                ovf_clr = 1'b0;
                check("ovf_cleared", {31'd0, overflow}, 32'd0);
            end
            measure_busy(len, peak, fs);
        join
        check("ovf_busy_len", len, 32'd200);
        check("ovf_peak", peak, 32'd4);
        check("ovf_full_seen", {31'd0, fs}, 32'd1);
        repeat (5) @(negedge clk);

        // 5: reset mid-frame
        write_seq(8'hFF, 2, 0);
        check("rst_pre_busy", {31'd0, tx_busy}, 32'd1);
        repeat (13) @(negedge clk);
        rstn = 1'b0;
        #1;
        check("rst_tx", {31'd0, tx_serial}, 32'd1);
        check("rst_busy", {31'd0, tx_busy}, 32'd0);
        check("rst_count", {29'd0, fifo_count}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx_busy || !tx_serial) seen = 1'b1;
        end
        check("rst_no_residual", {31'd0, seen}, 32'd0);
        check("rst_count_after", {29'd0, fifo_count}, 32'd0);

        // 6: write on the last STOP cycle with an empty FIFO
        fork
            begin
                write_o = 1'b1;
                C_in = 8'h3C;
                sb.push_back(8'h3C);
                @(negedge clk);
                write_o = 1'b0;
                repeat (40) @(negedge clk);
                check("edge_stop_tx", {31'd0, tx_serial}, 32'd1);
                check("edge_pre_count", {29'd0, fifo_count}, 32'd0);
                write_o = 1'b1;
                C_in = 8'hC3;
                sb.push_back(8'hC3);
                @(negedge clk);
                write_o = 1'b0;
                check("edge_count", {29'd0, fifo_count}, 32'd0);
                check("edge_no_gap", {31'd0, tx_serial}, 32'd0);
            end
            measure_busy(len, peak, fs);
        join
        check("edge_busy_len", len, 32'd80);

        repeat (20) @(negedge clk);
        check("sb_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
